fft_result_checker: RTL and testbench
=====================================

Name: fft_result_checker

Overview:
- Synthesizable, parametrised result checker for CoreFFT output streams (in-place or streaming).
- Compares DATAO_RE/DATAO_IM against an external golden memory, per frame and per golden bank.
- Generalises the ping/pong two-set bench check to NBANKS golden sets, with an error tolerance, mismatch counting and frame statistics.
- Sits beside the FFT core in benches and on-silicon BIST builds.

Parameters:
- WIDTH, 10, bits per real/imag component (signed two's complement).
- POINTS, 32, samples per frame; power of two, 8..65536.
- NBANKS, 2, number of golden result sets; power of two, >=1.
- TOL, 0, max allowed absolute error per component; 0 = bit-exact.
- CNTW, 16, width of the mismatch and frame counters.

Ports:
- CLK  in  1  core clock.
- NGRST  in  1  asynchronous active-low reset.
- OUTP_READY  in  1  FFT output-frame window (level); high while a frame is being unloaded.
- DATAO_VALID  in  1  output sample strobe.
- DATAO_RE  in  WIDTH  FFT real output.
- DATAO_IM  in  WIDTH  FFT imaginary output.
- BANK_SEL  in  log2(NBANKS) (min 1)  golden set for the next frame; sampled at frame start.
- GOLD_ADDR  out  log2(NBANKS)+log2(POINTS)  {bank, index} address to the golden memory (asynchronous read).
- GOLD_RE  in  WIDTH  golden real value at GOLD_ADDR, same cycle.
- GOLD_IM  in  WIDTH  golden imaginary value at GOLD_ADDR, same cycle.
- FRAME_DONE  out  1  one-cycle pulse when a frame verdict is valid.
- FRAME_PASS  out  1  verdict of the last frame; held until the next FRAME_DONE.
- MISMATCH_CNT  out  CNTW  mismatching samples in the last frame; saturating.
- FRAME_CNT  out  CNTW  completed frames since reset; wraps.
- FAILURE  out  1  sticky: any frame failed since reset.
- MAX_ERR  out  WIDTH+1  max absolute component error (see Optional Feature).

Behaviour:
- Reset (NGRST low, asynchronous): all outputs 0, FSM to IDLE, index 0, bank 0. Reset mid-frame abandons the frame; no FRAME_DONE is issued for it.
- OUTP_READY is registered once (rdy_q). Rise = rdy_q==0 and OUTP_READY==1; fall = rdy_q==1 and OUTP_READY==0.
- FSM states IDLE, RUN, FLUSH, DONE.
- IDLE -> RUN on rise: latch BANK_SEL, clear index, frame mismatch count, short/overrun flags and max error.
- A sample arriving in the rise cycle is accepted.
- RUN: every DATAO_VALID cycle is one accepted sample.
  - GOLD_ADDR = {bank, index} combinationally, every cycle.
  - diff = sign-extended (DATAO - GOLD) in WIDTH+1 bits per component.
  - err = |diff_re| > TOL or |diff_im| > TOL.
  - err is registered (stage 1). The mismatch counter adds it at the next edge and saturates at 2^CNTW-1.
  - index increments per accepted sample.
  - Index reaching POINTS sets overrun; index then holds at POINTS-1 and each further sample counts as a mismatch.
- RUN -> FLUSH on fall. A DATAO_VALID in the fall cycle is still accepted.
- FLUSH lasts 1 cycle and drains stage 1.
  - Samples with DATAO_VALID in FLUSH or IDLE are ignored.
  - short = accepted count < POINTS.
- FLUSH -> DONE: FRAME_DONE=1 for one cycle.
  - FRAME_PASS = !(mismatch>0 | short | overrun).
  - MISMATCH_CNT is updated.
  - FRAME_CNT += 1.
  - FAILURE |= !FRAME_PASS.
- DONE -> IDLE unconditionally. A rise seen in the DONE cycle goes straight to RUN.
- FRAME_DONE is therefore 2 cycles after the fall cycle.
- Back-to-back frames need >=1 low cycle of OUTP_READY; a rise during FLUSH is held pending and taken in DONE.
- NBANKS=1: BANK_SEL is ignored and the bank field of GOLD_ADDR is 0.

Optional Feature:
- Macro FFT_CHK_MAXERR_EN.
- Defined: a WIDTH+1-bit register tracks max(|diff_re|, |diff_im|) over accepted samples; it is cleared at frame start and copied to MAX_ERR at FRAME_DONE.
- Not defined: MAX_ERR tied to 0 and no tracking logic is built. All other behaviour is identical.

Test Plan:
- Exact match: POINTS=32, TOL=0, 32 samples equal to golden bank 0. Required: FRAME_DONE 2 cycles after the fall, FRAME_PASS=1, MISMATCH_CNT=0, FRAME_CNT=1, FAILURE=0.
- Tolerance: TOL=1. Sample 5 has re off by +1 and sample 9 has im off by -2. Required: MISMATCH_CNT=1, FRAME_PASS=0, FAILURE=1; with the macro, MAX_ERR=2.
- Bank switching: NBANKS=2, frames alternate BANK_SEL 0/1 with matching data. Required: GOLD_ADDR MSB follows the latched bank, all 4 frames pass, FRAME_CNT=4.
- Short/overrun: a 31-sample frame gives FRAME_PASS=0 with MISMATCH_CNT=0. A 34-sample frame gives MISMATCH_CNT=2 and FRAME_PASS=0.
- Edge cases: the last valid sample coincides with the fall and is counted. NGRST is pulsed low at sample 10 of a frame: all outputs become 0 asynchronously, no FRAME_DONE follows, and the next full frame passes.
- Extremes: WIDTH=10, data -512 vs golden +511, TOL=0. Required: no overflow, mismatch counted; with the macro, MAX_ERR=1023.

Source files
------------

// File: rtl/fft_result_checker.sv
// Per-frame checker for CoreFFT output streams against an external golden memory.
// Optional max-error tracking is built when FFT_CHK_MAXERR_EN is defined.
module fft_result_checker #(
  parameter int WIDTH  = 10,
  parameter int POINTS = 32,
  parameter int NBANKS = 2,
  parameter int TOL    = 0,
  parameter int CNTW   = 16,
  localparam int IW    = $clog2(POINTS),
  localparam int ABW   = $clog2(NBANKS),
  localparam int BW    = (ABW > 0) ? ABW : 1,
  localparam int AW    = ABW + IW
) (
  input  logic             CLK,
  input  logic             NGRST,
  input  logic             OUTP_READY,
  input  logic             DATAO_VALID,
  input  logic [WIDTH-1:0] DATAO_RE,
  input  logic [WIDTH-1:0] DATAO_IM,
  input  logic [BW-1:0]    BANK_SEL,
  output logic [AW-1:0]    GOLD_ADDR,
  input  logic [WIDTH-1:0] GOLD_RE,
  input  logic [WIDTH-1:0] GOLD_IM,
  output logic             FRAME_DONE,
  output logic             FRAME_PASS,
  output logic [CNTW-1:0]  MISMATCH_CNT,
  output logic [CNTW-1:0]  FRAME_CNT,
  output logic             FAILURE,
  output logic [WIDTH:0]   MAX_ERR
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [WIDTH:0] TOLV = (WIDTH+1)'(TOL);

  state_t          state;
  logic            rdyQ, pend, full, overrun, errQ;
  logic [BW-1:0]   bank;
  logic [IW-1:0]   idx;
  logic [CNTW-1:0] mm;

  logic            rise, fall, startNow, accept, curFull, err;
  logic [BW-1:0]   curBank;
  logic [IW-1:0]   curIdx;
  logic [WIDTH:0]  dRe, dIm, aRe, aIm;
  logic [CNTW-1:0] mmNext;

  // Rise is masked by reset so the address bus reads 0 while NGRST is low.
  assign rise     = NGRST && !rdyQ && OUTP_READY;
  assign fall     = rdyQ && !OUTP_READY;
  assign startNow = ((state == IDLE) && rise) || ((state == DONE) && (rise || pend));
  assign accept   = DATAO_VALID && (startNow || (state == RUN));

  // The frame-start cycle addresses the golden memory before bank/index register.
  assign curBank = startNow ? BANK_SEL : bank;
  assign curIdx  = startNow ? '0 : idx;
  assign curFull = startNow ? 1'b0 : full;

  generate
    if (NBANKS > 1) begin : g_bank
      assign GOLD_ADDR = {curBank, curIdx};
    end else begin : g_nobank
      assign GOLD_ADDR = curIdx;
    end
  endgenerate

  assign dRe = {DATAO_RE[WIDTH-1], DATAO_RE} - {GOLD_RE[WIDTH-1], GOLD_RE};
  assign dIm = {DATAO_IM[WIDTH-1], DATAO_IM} - {GOLD_IM[WIDTH-1], GOLD_IM};
  assign aRe = dRe[WIDTH] ? (~dRe + 1'b1) : dRe;
  assign aIm = dIm[WIDTH] ? (~dIm + 1'b1) : dIm;
  // Samples beyond the frame length always count as mismatches.
  assign err = (aRe > TOLV) || (aIm > TOLV) || curFull;

  assign mmNext = (errQ && (mm != '1)) ? mm + CNTW'(1) : mm;

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      state        <= IDLE;
      rdyQ         <= 1'b0;
      pend         <= 1'b0;
      full         <= 1'b0;
      overrun      <= 1'b0;
      errQ         <= 1'b0;
      bank         <= '0;
      idx          <= '0;
      mm           <= '0;
      FRAME_DONE   <= 1'b0;
      FRAME_PASS   <= 1'b0;
      MISMATCH_CNT <= '0;
      FRAME_CNT    <= '0;
      FAILURE      <= 1'b0;
    end else begin
      rdyQ       <= OUTP_READY;
      errQ       <= accept && err;
      FRAME_DONE <= 1'b0;
      mm         <= mmNext;
      case (state)
        IDLE: ;
        RUN:  if (fall) state <= FLUSH;
        FLUSH: begin
          state        <= DONE;
          if (rise) pend <= 1'b1;
          FRAME_DONE   <= 1'b1;
          FRAME_PASS   <= (mmNext == '0) && full && !overrun;
          MISMATCH_CNT <= mmNext;
          FRAME_CNT    <= FRAME_CNT + CNTW'(1);
          FAILURE      <= FAILURE || !((mmNext == '0) && full && !overrun);
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (startNow) begin
        state   <= RUN;
        bank    <= BANK_SEL;
        pend    <= 1'b0;
        mm      <= '0;
        idx     <= '0;
        full    <= 1'b0;
        overrun <= 1'b0;
      end
      if (accept) begin
        if (curFull) overrun <= 1'b1;
        if (curIdx == IW'(POINTS-1)) full <= 1'b1;
        else                         idx  <= curIdx + IW'(1);
      end
    end
  end

`ifdef FFT_CHK_MAXERR_EN
  logic [WIDTH:0] maxQ, sErr;
  assign sErr = (aRe > aIm) ? aRe : aIm;

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      maxQ    <= '0;
      MAX_ERR <= '0;
    end else begin
      if (startNow)                     maxQ <= accept ? sErr : '0;
      else if (accept && (sErr > maxQ)) maxQ <= sErr;
      if (state == FLUSH) MAX_ERR <= maxQ;
    end
  end
`else
  assign MAX_ERR = '0;
`endif
endmodule

// File: tb/tb_fft_result_checker.sv
// Randomized scoreboard bench for fft_result_checker: a frame-level model pushes
// expected verdicts, a negedge monitor pops them on every FRAME_DONE.
module tb_fft_result_checker;
  localparam int W = 10, P = 32, NB = 2, TOL = 1, CW = 16;
  localparam int AW = 6, BW = 1;

  logic          CLK, NGRST, OUTP_READY, DATAO_VALID;
  logic [W-1:0]  DATAO_RE, DATAO_IM, GOLD_RE, GOLD_IM;
  logic [BW-1:0] BANK_SEL;
  logic [AW-1:0] GOLD_ADDR;
  logic          FRAME_DONE, FRAME_PASS, FAILURE;
  logic [CW-1:0] MISMATCH_CNT, FRAME_CNT;
  logic [W:0]    MAX_ERR;

  fft_result_checker #(.WIDTH(W), .POINTS(P), .NBANKS(NB), .TOL(TOL), .CNTW(CW)) dut (
    .CLK(CLK), .NGRST(NGRST), .OUTP_READY(OUTP_READY), .DATAO_VALID(DATAO_VALID),
    .DATAO_RE(DATAO_RE), .DATAO_IM(DATAO_IM), .BANK_SEL(BANK_SEL), .GOLD_ADDR(GOLD_ADDR),
    .GOLD_RE(GOLD_RE), .GOLD_IM(GOLD_IM), .FRAME_DONE(FRAME_DONE), .FRAME_PASS(FRAME_PASS),
    .MISMATCH_CNT(MISMATCH_CNT), .FRAME_CNT(FRAME_CNT), .FAILURE(FAILURE), .MAX_ERR(MAX_ERR));

  typedef struct {int pass; int mm; int fcnt; int fail; int maxe; longint doneCyc;} exp_t;

  logic signed [W-1:0] goldRe [NB*P];
  logic signed [W-1:0] goldIm [NB*P];
  assign GOLD_RE = goldRe[GOLD_ADDR];
  assign GOLD_IM = goldIm[GOLD_ADDR];

  exp_t   q[$];
  int     nChecks = 0, nFails = 0;
  int     expFrames = 0, expFail = 0;
  int     dRe[64], dIm[64];
  longint cyc = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (FRAME_DONE === 1'b1) begin
      if (q.size() == 0) check("unexpected_frame_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("done_cycle", cyc, e.doneCyc);
        check("frame_pass", FRAME_PASS, e.pass);
        check("mismatch_cnt", MISMATCH_CNT, e.mm);
        check("frame_cnt", FRAME_CNT, e.fcnt);
        check("failure", FAILURE, e.fail);
        check("max_err", MAX_ERR, e.maxe);
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic [W-1:0] re, input logic [W-1:0] im,
                       input logic [BW-1:0] bs);
    @(posedge CLK); #1;
    OUTP_READY = r; DATAO_VALID = v; DATAO_RE = re; DATAO_IM = im; BANK_SEL = bs;
  endtask

  task automatic clear_err();
    for (int i = 0; i < 64; i++) begin dRe[i] = 0; dIm[i] = 0; end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge CLK);
    if (q.size() > 0) begin check("drain_timeout", q.size(), 0); q.delete(); end
  endtask

  // n samples from golden bank plus dRe/dIm offsets; lof puts the last sample on the fall cycle.
  task automatic run_frame(input int bank, input int n, input bit lof, input int gap);
    logic [W-1:0] sRe[64], sIm[64];
    int mm, mx, g, a, dr, di, hi;
    exp_t e;
    mm = 0; mx = 0;
    for (int i = 0; i < n; i++) begin
      g = (i < P) ? i : P - 1;
      a = bank * P + g;
      sRe[i] = W'(int'(goldRe[a]) + dRe[i]);
      sIm[i] = W'(int'(goldIm[a]) + dIm[i]);
      dr = int'($signed(sRe[i])) - int'(goldRe[a]);
      di = int'($signed(sIm[i])) - int'(goldIm[a]);
      if (dr < 0) dr = -dr;
      if (di < 0) di = -di;
      if (i >= P || dr > TOL || di > TOL) mm++;
      if (dr > mx) mx = dr;
      if (di > mx) mx = di;
    end
    expFrames++;
    e.pass = (mm == 0 && n == P) ? 1 : 0;
    if (e.pass == 0) expFail = 1;
    e.mm = mm; e.fcnt = expFrames; e.fail = expFail;
`ifdef FFT_CHK_MAXERR_EN
    e.maxe = mx;
`else
    e.maxe = 0;
`endif
    hi = lof ? n - 1 : n;
    for (int c = 0; c < hi; c++) begin
      drive(1'b1, 1'b1, sRe[c], sIm[c], (c == 0) ? BW'(bank) : BW'($urandom));
      #1 check("gold_addr", GOLD_ADDR, bank * P + ((c < P) ? c : P - 1));
    end
    drive(1'b0, lof, lof ? sRe[n-1] : W'($urandom), lof ? sIm[n-1] : W'($urandom), BW'($urandom));
    if (lof) #1 check("gold_addr_fall", GOLD_ADDR, bank * P + ((n - 1 < P) ? n - 1 : P - 1));
    e.doneCyc = cyc + 2;
    q.push_back(e);
    // Strobes outside the window must be ignored.
    for (int c = 1; c < gap; c++) drive(1'b0, 1'($urandom), W'($urandom), W'($urandom), BW'($urandom));
  endtask

  initial begin
    NGRST = 1'b0; OUTP_READY = 1'b0; DATAO_VALID = 1'b0;
    DATAO_RE = '0; DATAO_IM = '0; BANK_SEL = '0;
    for (int i = 0; i < NB * P; i++) begin goldRe[i] = W'($urandom); goldIm[i] = W'($urandom); end
    repeat (3) @(posedge CLK);
    #3;
    check("rst_frame_done", FRAME_DONE, 0);
    check("rst_frame_cnt", FRAME_CNT, 0);
    check("rst_failure", FAILURE, 0);
    check("rst_gold_addr", GOLD_ADDR, 0);
    NGRST = 1'b1;
    repeat (2) @(posedge CLK);

    clear_err(); run_frame(0, 32, 0, 3);                     // exact match
    clear_err(); dRe[5] = 1; dIm[9] = -2; run_frame(0, 32, 0, 3); // tolerance
    clear_err();
    for (int f = 0; f < 4; f++) run_frame(f % 2, 32, 0, 2);  // bank switching
    run_frame(1, 31, 0, 3);                                  // short
    run_frame(0, 34, 0, 3);                                  // overrun
    run_frame(1, 32, 1, 3);                                  // last sample on fall
    goldRe[3] = 10'sd511; dRe[3] = -1023;                    // -512 vs +511
    run_frame(0, 32, 0, 3);
    clear_err();
    for (int f = 0; f < 8; f++) begin
      int nsel, k;
      clear_err();
      nsel = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++) begin
          dRe[$urandom_range(0, 31)] = $urandom_range(0, 6) - 3;
          dIm[$urandom_range(0, 31)] = $urandom_range(0, 6) - 3;
        end
      end
      run_frame($urandom_range(0, 1), (nsel == 0) ? 31 : (nsel == 4) ? 33 : 32,
                1'($urandom_range(0, 1)), $urandom_range(2, 4));
    end
    drain();

    // Reset mid-frame: outputs clear asynchronously and the frame yields no verdict.
    check("pre_rst_failure", FAILURE, 1);
    clear_err();
    for (int c = 0; c < 10; c++)
      drive(1'b1, 1'b1, W'(goldRe[c]), W'(goldIm[c]), 1'b0);
    #2 NGRST = 1'b0;
    #1;
    check("arst_frame_done", FRAME_DONE, 0);
    check("arst_frame_pass", FRAME_PASS, 0);
    check("arst_mismatch", MISMATCH_CNT, 0);
    check("arst_frame_cnt", FRAME_CNT, 0);
    check("arst_failure", FAILURE, 0);
    check("arst_max_err", MAX_ERR, 0);
    check("arst_gold_addr", GOLD_ADDR, 0);
    OUTP_READY = 1'b0; DATAO_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #3 NGRST = 1'b1;
    expFrames = 0; expFail = 0;
    repeat (4) @(posedge CLK);
    check("no_stale_verdict", q.size(), 0);
    run_frame(0, 32, 0, 3);
    drain();
    repeat (5) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
